// File: rtl/accum_scheduler.sv
// ---------------------------------------------------------------------------
// accum_scheduler
//
// Two requesters share one W-bit accumulator. Each turn arbitrates between
// the pending requests (round-robin on ties), latches the winner's operand,
// adds it to the accumulator, pulses that requester's ack, and returns to
// idle. Every turn takes three cycles: grant, add/ack, release.
//
// Ports
//   clk   in   1   clock; all state changes on the rising edge
//   rst   in   1   asynchronous reset, active low
//   req   in   2   per-requester add request
//   op0   in   W   operand of requester 0, sampled on its grant
//   op1   in   W   operand of requester 1, sampled on its grant
//   clr   in   1   clear acc and ovf (honoured only while idle)
//   gnt   out  2   one-hot grant, held for the whole turn
//   ack   out  2   one-cycle completion pulse for the granted requester
//   busy  out  1   high whenever a turn is in progress
//   acc   out  W   accumulator value
//   ovf   out  1   sticky carry-out flag
//   full  out  1   combinational: acc is all ones
// ---------------------------------------------------------------------------
module accum_scheduler #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [W-1:0] op0,
    input  logic [W-1:0] op1,
    input  logic         clr,
    output logic [1:0]   gnt,
    output logic [1:0]   ack,
    output logic         busy,
    output logic [W-1:0] acc,
    output logic         ovf,
    output logic         full
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t       state, state_d;
    logic [1:0]   gnt_d, ack_d;
    logic         busy_d;
    logic [W-1:0] acc_d;
    logic         ovf_d;
    logic [W-1:0] opl, opl_d;    // operand latched at the grant edge
    logic         last, last_d;  // index of the requester granted most recently
    logic         win;           // arbitration result for the current req
    logic [W:0]   sum;           // acc + operand with carry-out in the MSB

    // Round-robin: a tie goes to the requester that was not granted last.
    always_comb begin
        win = 1'b0;
        unique case (req)
            2'b10:   win = 1'b1;
            2'b11:   win = ~last;
            default: win = 1'b0;
        endcase
    end

    assign sum  = {1'b0, acc} + {1'b0, opl};
    assign full = (acc == '1);

    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        ack_d   = ack;
        busy_d  = busy;
        acc_d   = acc;
        ovf_d   = ovf;
        opl_d   = opl;
        last_d  = last;

        unique case (state)
            IDLE: begin
                gnt_d  = '0;
                ack_d  = '0;
                busy_d = 1'b0;
                // clr takes priority: no grant on the edge that clears.
                if (clr) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                end else if (req != '0) begin
                    state_d = GRANT;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    opl_d   = win ? op1 : op0;
                    last_d  = win;
                    busy_d  = 1'b1;
                end
            end

            GRANT: begin
                acc_d   = sum[W-1:0];
                ovf_d   = ovf | sum[W];
                ack_d   = gnt;
                busy_d  = 1'b1;
                state_d = ACK;
            end

            ACK: begin
                gnt_d   = '0;
                ack_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                gnt_d   = '0;
                ack_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Requester 0 must win the first tie after reset, so last starts at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            gnt   <= '0;
            ack   <= '0;
            busy  <= 1'b0;
            acc   <= '0;
            ovf   <= 1'b0;
            opl   <= '0;
            last  <= 1'b1;
        end else begin
            state <= state_d;
            gnt   <= gnt_d;
            ack   <= ack_d;
            busy  <= busy_d;
            acc   <= acc_d;
            ovf   <= ovf_d;
            opl   <= opl_d;
            last  <= last_d;
        end
    end

endmodule

// File: tb/tb_accum_scheduler.sv
module tb_accum_scheduler;

    localparam int unsigned W = 4;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         rst;
    logic [1:0]   req;
    logic [W-1:0] op0;
    logic [W-1:0] op1;
    logic         clr;
    logic [1:0]   gnt;
    logic [1:0]   ack;
    logic         busy;
    logic [W-1:0] acc;
    logic         ovf;
    logic         full;

    accum_scheduler #(.W(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .op0  (op0),
        .op1  (op1),
        .clr  (clr),
        .gnt  (gnt),
        .ack  (ack),
        .busy (busy),
        .acc  (acc),
        .ovf  (ovf),
        .full (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int req_v);
        checks++;
        if (act != req_v) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req_v, $time);
        end
    endtask

    // Expected completion of one turn: who gets the ack and what acc/ovf become.
    typedef struct {
        int win;
        int acc;
        int ovf;
    } exp_t;

    exp_t sb[$];

    // Turn-level reference: a turn starts when idle with req set and clr low,
    // the sum lands one edge later, and the next turn may start three edges
    // after the first.
    int m_acc, m_ovf, m_last, m_win, m_phase, p_acc, p_ovf;

    initial begin
        m_acc = 0; m_ovf = 0; m_last = 1; m_win = 0; m_phase = 0;
        p_acc = 0; p_ovf = 0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_acc = 0; m_ovf = 0; m_last = 1; m_win = 0; m_phase = 0;
                sb.delete();
            end else if (m_phase == 2) begin
                m_acc   = p_acc;
                m_ovf   = p_ovf;
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_phase = 0;
            end else if (clr) begin
                m_acc = 0;
                m_ovf = 0;
            end else if (req != 2'b00) begin
                int s;
                if (req == 2'b11) m_win = 1 - m_last;
                else              m_win = req[1] ? 1 : 0;
                m_last = m_win;
                s      = m_acc + (m_win == 1 ? int'(op1) : int'(op0));
                p_acc  = s % MOD;
                p_ovf  = (m_ovf != 0 || s >= MOD) ? 1 : 0;
                sb.push_back('{win: m_win, acc: p_acc, ovf: p_ovf});
                m_phase = 2;
            end
        end
    end

    // Monitor: compares every cycle against the model, and pops the
    // scoreboard whenever the DUT presents an ack.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                int eg;
                eg = (m_phase != 0) ? ((m_win == 1) ? 2 : 1) : 0;
                chk("gnt",  int'(gnt),  eg);
                chk("ack",  int'(ack),  (m_phase == 1) ? eg : 0);
                chk("acc",  int'(acc),  m_acc);
                chk("ovf",  int'(ovf),  m_ovf);
                chk("busy", int'(busy), (m_phase != 0) ? 1 : 0);
                chk("full", int'(full), (m_acc == MOD - 1) ? 1 : 0);
                if (ack != 2'b00) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected_ack actual=%0d required=none at t=%0t", ack, $time);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("sb_ack", int'(ack), (e.win == 1) ? 2 : 1);
                        chk("sb_acc", int'(acc), e.acc);
                        chk("sb_ovf", int'(ovf), e.ovf);
                    end
                end
            end
        end
    end

    task automatic drive(input logic [1:0] r, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic c);
        @(negedge clk);
        req = r;
        op0 = a;
        op1 = b;
        clr = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, '0, '0, 1'b0);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        req = '0;
        op0 = '0;
        op1 = '0;
        clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_acc",  int'(acc),  0);
        chk("rst_ovf",  int'(ovf),  0);
        chk("rst_gnt",  int'(gnt),  0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_full", int'(full), 0);

        // Single request from requester 0.
        drive(2'b01, 4'd3, 4'd0, 1'b0);
        idle(3);

        // Continuous tie after a fresh reset: 01,10,01,10 with acc 1,3,4,6.
        rst_pulse();
        for (int i = 0; i < 12; i++) drive(2'b11, 4'd1, 4'd2, 1'b0);
        idle(3);

        // Wrap-around: reach 15, add 1 (ovf set), then add 2 (ovf stays).
        drive(2'b00, '0, '0, 1'b1);
        drive(2'b01, 4'd15, 4'd0, 1'b0);
        idle(2);
        drive(2'b10, 4'd0, 4'd1, 1'b0);
        idle(2);
        drive(2'b10, 4'd0, 4'd2, 1'b0);
        idle(3);

        // clr together with req in idle: clear only, grant on the next edge.
        drive(2'b01, 4'd5, 4'd0, 1'b1);
        drive(2'b01, 4'd5, 4'd0, 1'b0);
        idle(3);

        // Reset during GRANT: everything clears at once, no ack follows.
        drive(2'b01, 4'd7, 4'd0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_gnt",  int'(gnt),  0);
        chk("abort_ack",  int'(ack),  0);
        chk("abort_acc",  int'(acc),  0);
        chk("abort_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        idle(4);

        // Random traffic: requests, operands and clr change freely.
        for (int i = 0; i < 600; i++)
            drive(2'($urandom), W'($urandom), W'($urandom), ($urandom_range(0, 5) == 0));
        idle(4);
        chk("sb_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
